// File: rtl/proc_defs.sv
// Shared fetch-pipeline constants and FSM state encoding.
// Pure definitions; no logic.
// Imported by the fetch top and its IF/ID register.
package proc_defs;

    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam logic [15:0] NOP         = 16'h0000;
    localparam logic [15:0] HALT_OPCODE = 16'hFFFF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction word, its address and a valid bit.
// Latency: 1 cycle from load/flush to outputs; async active-low clear.
// Backpressure: holds contents whenever neither load nor flush is asserted.
module ifid_reg
    import proc_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pc_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc_o,
    output logic        valid_o
);

    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    // Flush wins over load; a flush keeps the old address so decode still
    // sees where the squashed slot came from.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= NOP;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, RUN/HALT FSM, IF/ID register.
// Latency: word at PC=N appears on IF/ID one cycle after PC=N.
// Backpressure: C_Stall holds PC and IF/ID; C_BranchTaken overrides stall.
module instruction_fetch
    import proc_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] A_InstrAddress,
    output logic        C_IMRead,
    input  logic [15:0] D_Instruction,
    input  logic        C_Stall,
    input  logic        C_BranchTaken,
    input  logic [15:0] A_BranchTarget,
    output logic [15:0] D_IFID_Instr,
    output logic [15:0] A_IFID_PC,
    output logic        C_IFID_Valid,
    output logic        C_Halted
);

    logic [15:0]  pc_q, pc_d;
    fetch_state_e state_q, state_d;
    logic         ifid_load;
    logic         ifid_flush;

    // Next-state: branch redirect beats stall; a latched HALT word freezes
    // the PC on its own address and parks the FSM until reset.
    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (C_BranchTaken) begin
                    pc_d       = A_BranchTarget;
                    ifid_flush = 1'b1;
                end else if (!C_Stall) begin
                    ifid_load = 1'b1;
                    if (D_Instruction == HALT_OPCODE) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + 16'd1;
                    end
                end
            end
            default: begin
                // HALT: everything holds.
            end
        endcase
    end

    // PC and FSM state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .instr_i (D_Instruction),
        .pc_i    (pc_q),
        .instr_o (D_IFID_Instr),
        .pc_o    (A_IFID_PC),
        .valid_o (C_IFID_Valid)
    );

    // Read enable is gated by reset so memory is idle while reset is held.
    assign A_InstrAddress = pc_q;
    assign C_IMRead       = rst && (state_q == ST_RUN);
    assign C_Halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] A_InstrAddress;
    logic        C_IMRead;
    logic [15:0] D_Instruction;
    logic        C_Stall;
    logic        C_BranchTaken;
    logic [15:0] A_BranchTarget;
    logic [15:0] D_IFID_Instr;
    logic [15:0] A_IFID_PC;
    logic        C_IFID_Valid;
    logic        C_Halted;

    int n_vec;
    int n_miss;

    logic [15:0] mem [0:65535];

    instruction_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .A_InstrAddress (A_InstrAddress),
        .C_IMRead       (C_IMRead),
        .D_Instruction  (D_Instruction),
        .C_Stall        (C_Stall),
        .C_BranchTaken  (C_BranchTaken),
        .A_BranchTarget (A_BranchTarget),
        .D_IFID_Instr   (D_IFID_Instr),
        .A_IFID_PC      (A_IFID_PC),
        .C_IFID_Valid   (C_IFID_Valid),
        .C_Halted       (C_Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign D_Instruction = mem[A_InstrAddress];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] pc, input logic [15:0] ipc,
                           input logic [15:0] ins, input logic vld, input logic hlt,
                           input logic rd);
        check({tag, ".pc"},     A_InstrAddress, pc);
        check({tag, ".ifidpc"}, A_IFID_PC,      ipc);
        check({tag, ".instr"},  D_IFID_Instr,   ins);
        check({tag, ".valid"},  {15'd0, C_IFID_Valid}, {15'd0, vld});
        check({tag, ".halted"}, {15'd0, C_Halted},     {15'd0, hlt});
        check({tag, ".imread"}, {15'd0, C_IMRead},     {15'd0, rd});
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h8000 | 16'(i & 16'h0FFF);
        mem[0]      = 16'h1111;
        mem[1]      = 16'h2222;
        mem[2]      = 16'h3333;
        mem[3]      = 16'h4444;
        mem[5]      = 16'hFFFF;
        mem[16'h40] = 16'h4040;
        mem[16'hFFFF] = 16'h7777;

        rst            = 1'b0;
        C_Stall        = 1'b0;
        C_BranchTaken  = 1'b0;
        A_BranchTarget = 16'h0000;

        // Reset held: all outputs at reset values, read disabled.
        #12;
        chk_all("rst_hold", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Release between edges: PC=0, nothing valid yet, reading.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("rst_rel", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Free run.
        step();
        chk_all("run0", 16'h0001, 16'h0000, 16'h1111, 1'b1, 1'b0, 1'b1);
        step();
        chk_all("run1", 16'h0002, 16'h0001, 16'h2222, 1'b1, 1'b0, 1'b1);

        // Stall 3 cycles at PC=2.
        C_Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all("stall", 16'h0002, 16'h0001, 16'h2222, 1'b1, 1'b0, 1'b1);
        end
        C_Stall = 1'b0;
        step();
        chk_all("unstall", 16'h0003, 16'h0002, 16'h3333, 1'b1, 1'b0, 1'b1);

        // Branch beats stall.
        C_Stall        = 1'b1;
        C_BranchTaken  = 1'b1;
        A_BranchTarget = 16'h0040;
        step();
        chk_all("br40", 16'h0040, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1);
        C_Stall       = 1'b0;
        C_BranchTaken = 1'b0;
        step();
        chk_all("br40_next", 16'h0041, 16'h0040, 16'h4040, 1'b1, 1'b0, 1'b1);

        // PC wraps from FFFF to 0000.
        C_BranchTaken  = 1'b1;
        A_BranchTarget = 16'hFFFF;
        step();
        chk_all("brFFFF", 16'hFFFF, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b1);
        C_BranchTaken = 1'b0;
        step();
        chk_all("wrap0", 16'h0000, 16'hFFFF, 16'h7777, 1'b1, 1'b0, 1'b1);
        step();
        chk_all("wrap1", 16'h0001, 16'h0000, 16'h1111, 1'b1, 1'b0, 1'b1);

        // HALT word on the wrong path is squashed by a branch.
        C_BranchTaken  = 1'b1;
        A_BranchTarget = 16'h0005;
        step();
        chk_all("br5", 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        A_BranchTarget = 16'h0040;
        step();
        chk_all("halt_squash", 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        A_BranchTarget = 16'h0005;
        step();
        chk_all("br5b", 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

        // HALT latched: valid, PC held, halted, read disabled.
        C_BranchTaken = 1'b0;
        step();
        chk_all("halt", 16'h0005, 16'h0005, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        C_BranchTaken  = 1'b1;
        C_Stall        = 1'b1;
        A_BranchTarget = 16'h0040;
        step();
        chk_all("halt_ign_br", 16'h0005, 16'h0005, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        C_BranchTaken = 1'b0;
        C_Stall       = 1'b0;
        step();
        chk_all("halt_ign", 16'h0005, 16'h0005, 16'hFFFF, 1'b1, 1'b1, 1'b0);

        // Async reset out of HALT.
        #2;
        rst = 1'b0;
        #1;
        chk_all("rst_halt", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk_all("rerun0", 16'h0001, 16'h0000, 16'h1111, 1'b1, 1'b0, 1'b1);

        // Async reset in the middle of a stall, with no clock edge.
        C_Stall = 1'b1;
        step();
        chk_all("stall2", 16'h0001, 16'h0000, 16'h1111, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_all("rst_stall", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        C_Stall = 1'b0;
        rst     = 1'b1;
        step();
        chk_all("restart0", 16'h0001, 16'h0000, 16'h1111, 1'b1, 1'b0, 1'b1);
        step();
        chk_all("restart1", 16'h0002, 16'h0001, 16'h2222, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
